// File: rtl/lstm_fixed_pkg.sv
// Shared Q8.8 fixed-point definitions for the LSTM datapath.
// Constants, stage bundles and saturating helpers.
package lstm_fixed_pkg;

    localparam int Q_W    = 16;
    localparam int Q_FRAC = 8;

    localparam logic [Q_W-1:0] ONE  = 16'h0100;
    localparam logic [Q_W-1:0] HALF = 16'h0080;
    localparam logic [Q_W-1:0] LSB  = 16'h0001;

    localparam logic [Q_W-1:0] BP1 = 16'h0100;
    localparam logic [Q_W-1:0] BP2 = 16'h0260;
    localparam logic [Q_W-1:0] BP3 = 16'h0500;

    localparam logic [Q_W-1:0] IC0 = HALF;
    localparam logic [Q_W-1:0] IC1 = 16'h00A0;
    localparam logic [Q_W-1:0] IC2 = 16'h00D8;

    localparam logic [Q_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [Q_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic {
        FUNC_SIGMOID = 1'b0,
        FUNC_TANH    = 1'b1
    } func_e;

    typedef enum logic [1:0] {
        SEG_LIN0 = 2'd0,
        SEG_LIN1 = 2'd1,
        SEG_LIN2 = 2'd2,
        SEG_SAT  = 2'd3
    } seg_e;

    typedef struct packed {
        logic [Q_W-1:0] mag;
        logic           neg;
        func_e          func;
    } s1_t;

    typedef struct packed {
        logic [Q_W-1:0] s;
        seg_e           seg;
        logic           neg;
        func_e          func;
    } s2_t;

    // Magnitude of a signed word; the most negative value clips to SAT_MAX.
    function automatic logic [Q_W-1:0] sat_abs(input logic [Q_W-1:0] x);
        logic [Q_W-1:0] r;
        if (x == SAT_MIN) begin
            r = SAT_MAX;
        end else if (x[Q_W-1]) begin
            r = ~x + LSB;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Doubles a non-negative magnitude, clipping at SAT_MAX.
    function automatic logic [Q_W-1:0] sat_dbl(input logic [Q_W-1:0] a);
        logic [Q_W-1:0] r;
        if (a[Q_W-1] || a[Q_W-2]) begin
            r = SAT_MAX;
        end else begin
            r = {a[Q_W-2:0], 1'b0};
        end
        return r;
    endfunction

endpackage

// File: rtl/pwl_sigmoid_core.sv
// Piecewise-linear sigmoid for a non-negative Q8.8 magnitude.
// Purely combinational; also reports which segment was used.
module pwl_sigmoid_core
    import lstm_fixed_pkg::*;
(
    input  logic [Q_W-1:0] a,
    output logic [Q_W-1:0] s,
    output seg_e           seg
);

    // Pick the segment by breakpoint, highest first.
    always_comb begin
        seg = SEG_LIN0;
        if (a >= BP3) begin
            seg = SEG_SAT;
        end else if (a >= BP2) begin
            seg = SEG_LIN2;
        end else if (a >= BP1) begin
            seg = SEG_LIN1;
        end else begin
            seg = SEG_LIN0;
        end
    end

    // Evaluate the selected line with truncating shifts.
    always_comb begin
        s = IC0;
        unique case (seg)
            SEG_SAT:  s = ONE;
            SEG_LIN2: s = (a >> 5) + IC2;
            SEG_LIN1: s = (a >> 3) + IC1;
            SEG_LIN0: s = (a >> 2) + IC0;
            default:  s = IC0;
        endcase
    end

endmodule

// File: rtl/gate_activation.sv
// Three-stage Q8.8 sigmoid/tanh activation with valid/ready on both sides.
// S1: magnitude/doubling, S2: PWL sigmoid, S3: sign and tanh rescale.
module gate_activation
    import lstm_fixed_pkg::*;
#(
    parameter int DATA_WIDTH  = Q_W,
    parameter int FRACT_WIDTH = Q_FRAC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_func,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam logic [Q_W-1:0] UNIT     = Q_W'(1 << FRACT_WIDTH);
    localparam logic [Q_W-1:0] NEG_UNIT = ~UNIT + LSB;

    logic v1;
    logic v2;
    logic v3;
    logic ld1;
    logic ld2;
    logic ld3;

    s1_t            s1_d;
    s1_t            s1_q;
    s2_t            s2_d;
    s2_t            s2_q;
    logic [Q_W-1:0] res_d;
    logic [Q_W-1:0] res_q;
    logic [Q_W-1:0] tval;
    logic [Q_W-1:0] core_s;
    seg_e           core_seg;

    // A stage may load when empty or when its contents move on.
    always_comb begin
        ld3 = !v3 || out_ready;
        ld2 = !v2 || ld3;
        ld1 = !v1 || ld2;
    end

    assign in_ready  = ld1;
    assign out_valid = v3;
    assign out_data  = res_q;

    // Stage 1 input: magnitude, sign, and tanh doubling.
    always_comb begin
        s1_d      = '0;
        s1_d.neg  = in_data[DATA_WIDTH-1];
        s1_d.func = func_e'(in_func);
        s1_d.mag  = sat_abs(in_data);
        if (s1_d.func == FUNC_TANH) begin
            s1_d.mag = sat_dbl(s1_d.mag);
        end
    end

    pwl_sigmoid_core u_core (
        .a   (s1_q.mag),
        .s   (core_s),
        .seg (core_seg)
    );

    // Stage 2 input: core result plus carried sign/func.
    always_comb begin
        s2_d      = '0;
        s2_d.s    = core_s;
        s2_d.seg  = core_seg;
        s2_d.neg  = s1_q.neg;
        s2_d.func = s1_q.func;
    end

    // Stage 3 input: apply sign and the tanh 2s-1 rescale.
    always_comb begin
        res_d = '0;
        tval  = {s2_q.s[Q_W-2:0], 1'b0} - UNIT;
        if (s2_q.seg == SEG_SAT) begin
            if (s2_q.func == FUNC_TANH) begin
                res_d = s2_q.neg ? NEG_UNIT : UNIT;
            end else begin
                res_d = s2_q.neg ? '0 : UNIT;
            end
        end else if (s2_q.func == FUNC_TANH) begin
            res_d = s2_q.neg ? (~tval + LSB) : tval;
        end else begin
            res_d = s2_q.neg ? (UNIT - s2_q.s) : s2_q.s;
        end
    end

    // Valid bits advance with their stage loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld2) v2 <= v1;
            if (ld3) v3 <= v2;
        end
    end

    // Stage 1 register; only real items overwrite it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else if (ld1 && in_valid) begin
            s1_q <= s1_d;
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q <= '0;
        end else if (ld2 && v1) begin
            s2_q <= s2_d;
        end
    end

    // Stage 3 register; holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (ld3 && v2) begin
            res_q <= res_d;
        end
    end

endmodule

// File: tb/tb_gate_activation.sv
// Self-checking bench for gate_activation: directed points,
// streaming, backpressure, random handshakes and mid-run reset.
module tb_gate_activation;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_func;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rx_cnt = 0;
    bit          mon_en = 1'b0;
    bit          rnd_on = 1'b0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] din;
        logic        func;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t tv[12];

    gate_activation dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_func   (in_func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_model(input logic [15:0] x,
                                              input logic f);
        int xi;
        int a;
        int s;
        int r;
        xi = int'($signed(x));
        a  = (xi < 0) ? -xi : xi;
        if (a > 32767) a = 32767;
        if (f) begin
            a = a * 2;
            if (a > 32767) a = 32767;
        end
        if (a >= 1280)     s = 256;
        else if (a >= 608) s = (a >> 5) + 216;
        else if (a >= 256) s = (a >> 3) + 160;
        else               s = (a >> 2) + 128;
        if (!f) begin
            r = (xi < 0) ? 256 - s : s;
        end else begin
            r = 2 * s - 256;
            if (xi < 0) r = -r;
        end
        return 16'(r);
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: handshakes are sampled mid-cycle, where they are stable.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_extra: got %h, expected none", out_data);
                end else begin
                    chk("sb_data", out_data, exp_q.pop_front());
                end
                rx_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_data, in_func));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one item and hold it until accepted; returns 1 after that edge.
    task automatic offer(input logic [15:0] d, input logic f);
        int w;
        in_valid = 1'b1;
        in_data  = d;
        in_func  = f;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic point(input string name, input logic [15:0] d,
                         input logic f, input logic [15:0] exp);
        offer(d, f);
        chk({name, "_v1"}, {15'd0, out_valid}, 16'h0000);
        step();
        chk({name, "_v2"}, {15'd0, out_valid}, 16'h0000);
        step();
        chk({name, "_valid"}, {15'd0, out_valid}, 16'h0001);
        chk({name, "_data"}, out_data, exp);
        step();
    endtask

    logic [15:0] held;
    bit          have;
    int          stall;

    initial begin
        tv[0]  = '{16'h0000, 1'b0, 16'h0080, "sig_0"};
        tv[1]  = '{16'h0100, 1'b0, 16'h00C0, "sig_p1"};
        tv[2]  = '{16'hFF00, 1'b0, 16'h0040, "sig_m1"};
        tv[3]  = '{16'h0600, 1'b0, 16'h0100, "sig_sat"};
        tv[4]  = '{16'h00FF, 1'b0, 16'h00BF, "sig_bp1m"};
        tv[5]  = '{16'h04FF, 1'b0, 16'h00FF, "sig_bp3m"};
        tv[6]  = '{16'h8000, 1'b0, 16'h0000, "sig_min"};
        tv[7]  = '{16'h0000, 1'b1, 16'h0000, "tanh_0"};
        tv[8]  = '{16'h0100, 1'b1, 16'h00C0, "tanh_p1"};
        tv[9]  = '{16'hFF00, 1'b1, 16'hFF40, "tanh_m1"};
        tv[10] = '{16'h8000, 1'b1, 16'hFF00, "tanh_min"};
        tv[11] = '{16'h7FFF, 1'b1, 16'h0100, "tanh_max"};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_func   = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_in_ready", {15'd0, in_ready}, 16'h0001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            point(tv[i].name, tv[i].din, tv[i].func, tv[i].exp);
        end

        mon_en = 1'b1;
        rx_cnt = 0;
        stall  = 0;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            in_func  = i[0];
            @(negedge clk);
            if (!in_ready) stall++;
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        chk("stream_stalls", 16'(stall), 16'd0);
        chk("stream_count", 16'(rx_cnt), 16'd64);
        chk("stream_left", 16'(exp_q.size()), 16'd0);

        rx_cnt    = 0;
        out_ready = 1'b0;
        have      = 1'b0;
        held      = '0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    offer(16'(k * 256 + 64), k[0]);
                end
            end
            begin
                repeat (6) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (have) chk("bp_hold", out_data, held);
                        else begin
                            held = out_data;
                            have = 1'b1;
                        end
                    end
                end
                chk("bp_in_ready", {15'd0, in_ready}, 16'h0000);
                chk("bp_out_valid", {15'd0, out_valid}, 16'h0001);
                chk("bp_no_rx", 16'(rx_cnt), 16'd0);
                step();
                out_ready = 1'b1;
            end
        join
        repeat (6) step();
        chk("bp_count", 16'(rx_cnt), 16'd5);
        chk("bp_left", 16'(exp_q.size()), 16'd0);

        rx_cnt = 0;
        rnd_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    offer(16'($urandom), 1'($urandom_range(0, 1)));
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        repeat (5) step();
        chk("rnd_count", 16'(rx_cnt), 16'd1000);
        chk("rnd_left", 16'(exp_q.size()), 16'd0);

        mon_en    = 1'b0;
        out_ready = 1'b0;
        offer(16'h0200, 1'b0);
        offer(16'h0300, 1'b1);
        offer(16'hFD00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("mid_rst_out_data", out_data, 16'h0000);
        chk("mid_rst_in_ready", {15'd0, in_ready}, 16'h0001);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_idle", {15'd0, out_valid}, 16'h0000);
        end
        step();
        point("post_rst", 16'h0100, 1'b0, 16'h00C0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_activation.md
# gate_activation

Pipelined Q8.8 activation unit that sits directly downstream of the weighted-sum stage (W·x + U·h) in the LSTM cell. It applies a piecewise-linear sigmoid (for i/f/o gates) or tanh (for the candidate and cell output) to each pre-activation sum. It uses valid/ready handshakes on both sides, sustains one result per cycle, and has a 3-cycle latency.

## Interface
- DATA_WIDTH, 16, total word width; signed two's complement.
- FRACT_WIDTH, 8, fractional bits (Q8.8); the segment constants are defined for this value only.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  in_data/in_func valid this cycle.
- in_ready  out  1  stage 1 can accept this cycle.
- in_data  in  DATA_WIDTH  pre-activation sum, signed Q8.8.
- in_func  in  1  0 = sigmoid, 1 = tanh; travels with the data.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  DATA_WIDTH  activation result, signed Q8.8.

## Operation
- Transfers happen on cycles where valid and ready are both high; an input is accepted iff in_valid && in_ready.
- Sigmoid core s(a), with a ≥ 0 in Q8.8 and shifts truncating:
  - a ≥ 0x0500 → 0x0100.
  - a ≥ 0x0260 → (a>>5) + 0x00D8.
  - a ≥ 0x0100 → (a>>3) + 0x00A0.
  - otherwise → (a>>2) + 0x0080.
- Sigmoid:
  - a = |x|.
  - Result is s(a) for x ≥ 0, and 0x0100 − s(a) for x < 0.
- Tanh:
  - a = sat(2·|x|); the doubling saturates to 0x7FFF.
  - t = 2·s(a) − 0x0100.
  - Result is t for x ≥ 0, and −t for x < 0.
- |0x8000| saturates to 0x7FFF; no wrap-around anywhere.
- Outputs are always within [0x0000, 0x0100] for sigmoid and [0xFF00, 0x0100] for tanh.

## Timing
- Pipeline stages, each with its own valid bit:
  - S1 registers |x|, sign, and func; it also applies the tanh doubling.
  - S2 registers segment select and s(a).
  - S3 registers the final result, which drives out_data.
- Stage k loads when !v_k || (stage k+1 loads), where stage 4's load is out_ready. in_ready = !v1 || S2 loads (combinational from state and out_ready).
- Latency is 3 cycles from the accepting edge to out_valid high, with no stall. Throughput is 1 per cycle with out_ready held high.
- Stall behaviour:
  - While out_valid && !out_ready, out_data and out_valid hold stable.
  - Upstream stages keep filling until all three are full; in_ready then drops.
  - A bubble closes on the next out_ready cycle.
  - Simultaneous accept at input and output in a full pipe is legal; no item is lost or duplicated.
- Reset state (asynchronous, while rst_n is low):
  - Valid bits, out_valid, and out_data are 0x0000.
  - in_ready = 1.
  - Reset mid-operation discards all in-flight items; nothing is emitted after release until new inputs are accepted.
- in_func is sampled only with in_data; changing it mid-stream affects only subsequently accepted items.

## Structure
- Shared package lstm_fixed_pkg holds:
  - Q8.8 constants: ONE = 0x0100, HALF = 0x0080.
  - Segment breakpoints 0x0100, 0x0260, 0x0500.
  - Intercepts 0x0080, 0x00A0, 0x00D8.
  - Saturation limits 0x7FFF/0x8000.
  - The func encoding (FUNC_SIGMOID = 0, FUNC_TANH = 1).
- One combinational sub-module, pwl_sigmoid_core: a ≥ 0 in, s(a) out. It is used in S2 for both functions; gate_activation owns the pipeline, handshake, sign handling and tanh rescale.

## Test plan
- Sigmoid points with out_ready = 1:
  - 0x0000 → 0x0080.
  - 0x0100 → 0x00C0.
  - 0xFF00 → 0x0040.
  - 0x0600 → 0x0100.
  - Each appears exactly 3 cycles after acceptance.
- Tanh points:
  - 0x0000 → 0x0000.
  - 0x0100 → 0x00C0.
  - 0xFF00 → 0xFF40.
  - 0x8000 → 0xFF00 (abs and doubling saturation).
- Back-to-back stream of 64 random inputs with alternating in_func, out_ready = 1: one output per cycle, in order, matching the bit-exact reference model.
- Backpressure:
  - Hold out_ready = 0 for 6 cycles after 5 inputs are offered. in_ready drops once 3 items are held and out_data stays stable.
  - Releasing out_ready drains all 5 in order with no loss or duplication.
- Random in_valid/out_ready toggling over 1000 items: output sequence equals input sequence mapped through the model; no X on out_data when out_valid = 1.
- Assert rst_n low for 1 cycle with 3 items in flight: out_valid = 0 and out_data = 0x0000 immediately; no stale item emerges after release. The next input 0x0100 (sigmoid) yields 0x00C0 after 3 cycles.
